// File: rtl/rs_operand_arbiter.sv
// Round-robin arbiter between the immediate and register-file operand sources.
// It feeds a one-entry output register with a valid/ready handshake and keeps saturating per-source grant counters.
module rs_operand_arbiter #(
    parameter int N  = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [N:0]    ibits,
    output logic          i_ready,
    input  logic          r_valid,
    input  logic [N:0]    rbits,
    output logic          r_ready,
    output logic          mux_sel,
    output logic          out_valid,
    output logic [N:0]    out_bits,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_i,
    output logic [CW-1:0] cnt_r,
    input  logic          cnt_clr
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t   state_reg, state_next;
    logic     last_sel_reg;            // 1 = imm granted last, 0 = reg
    logic     mux_sel_reg;
    logic [N:0] out_bits_reg;

    logic load_en;
    logic grant_imm;
    logic grant_reg;
    logic any_grant;

    assign out_valid = (state_reg == FULL);
    assign load_en   = !out_valid || out_ready;

    // On a tie the source opposite to the previous winner is granted.
    assign grant_imm = load_en && i_valid && (!r_valid || !last_sel_reg);
    assign grant_reg = load_en && r_valid && (!i_valid ||  last_sel_reg);
    assign any_grant = grant_imm || grant_reg;

    assign i_ready  = grant_imm && !reset;
    assign r_ready  = grant_reg && !reset;
    assign mux_sel  = mux_sel_reg;
    assign out_bits = out_bits_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (any_grant) state_next = FULL;
            FULL:  if (out_ready && !any_grant) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bits_reg <= '0;
            mux_sel_reg  <= 1'b0;
            last_sel_reg <= 1'b0;
        end else if (any_grant) begin
            out_bits_reg <= grant_imm ? ibits : rbits;
            mux_sel_reg  <= grant_imm;
            last_sel_reg <= grant_imm;
        end
    end

    // Index 1 tracks immediate grants, index 0 register grants.
    logic [1:0]          grant_vec;
    logic [1:0][CW-1:0]  cnt_bus;

    assign grant_vec = {grant_imm, grant_reg};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CW-1:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (grant_vec[gi] && (cnt_reg != {CW{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign cnt_bus[gi] = cnt_reg;
    end

    assign cnt_i = cnt_bus[1];
    assign cnt_r = cnt_bus[0];

endmodule

// File: tb/tb_rs_operand_arbiter.sv
// Directed bench for rs_operand_arbiter, built with 2-bit counters so that saturation is reachable.
module tb_rs_operand_arbiter;

    localparam int N  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [N:0]    ibits;
    logic          i_ready;
    logic          r_valid;
    logic [N:0]    rbits;
    logic          r_ready;
    logic          mux_sel;
    logic          out_valid;
    logic [N:0]    out_bits;
    logic          out_ready;
    logic [CW-1:0] cnt_i;
    logic [CW-1:0] cnt_r;
    logic          cnt_clr;

    int vectors = 0;
    int errs    = 0;

    rs_operand_arbiter #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .ibits     (ibits),
        .i_ready   (i_ready),
        .r_valid   (r_valid),
        .rbits     (rbits),
        .r_ready   (r_ready),
        .mux_sel   (mux_sel),
        .out_valid (out_valid),
        .out_bits  (out_bits),
        .out_ready (out_ready),
        .cnt_i     (cnt_i),
        .cnt_r     (cnt_r),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b1; r_valid = 1'b1;
        ibits = 3'b101; rbits = 3'b010; out_ready = 1'b1; cnt_clr = 1'b0;

        // Reset held with both requesters active
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bits",  out_bits,  0);
        chk("rst_mux_sel",   mux_sel,   0);
        chk("rst_i_ready",   i_ready,   0);
        chk("rst_r_ready",   r_ready,   0);
        chk("rst_cnt_i",     cnt_i,     0);
        chk("rst_cnt_r",     cnt_r,     0);
        $display("vec reset: out_valid=%0d i_ready=%0d r_ready=%0d", out_valid, i_ready, r_ready);

        reset = 1'b0;
        #1;
        chk("first_tie_i_ready", i_ready, 1);
        chk("first_tie_r_ready", r_ready, 0);
        tick();
        chk("first_out_bits", out_bits, 3'b101);
        chk("first_mux_sel",  mux_sel,  1);
        chk("first_cnt_i",    cnt_i,    1);
        chk("first_out_valid", out_valid, 1);
        $display("vec first grant: out_bits=%b mux_sel=%0d cnt_i=%0d", out_bits, mux_sel, cnt_i);

        // Continuous contention alternates
        chk("rr_r_ready", r_ready, 1);
        tick();
        chk("rr2_out_bits", out_bits, 3'b010);
        chk("rr2_mux_sel",  mux_sel,  0);
        tick();
        chk("rr3_out_bits", out_bits, 3'b101);
        chk("rr3_mux_sel",  mux_sel,  1);
        tick();
        chk("rr4_out_bits", out_bits, 3'b010);
        chk("rr4_mux_sel",  mux_sel,  0);
        chk("rr_cnt_i", cnt_i, 2);
        chk("rr_cnt_r", cnt_r, 2);
        $display("vec round robin: cnt_i=%0d cnt_r=%0d", cnt_i, cnt_r);

        i_valid = 1'b0; r_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 0);
        $display("vec drain: out_valid=%0d", out_valid);

        // Backpressure
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt_i", cnt_i, 0);
        chk("clr_cnt_r", cnt_r, 0);
        r_valid = 1'b1; rbits = 3'b011;
        #1;
        chk("bp_load_r_ready", r_ready, 1);
        tick();
        chk("bp_load_out_bits", out_bits, 3'b011);
        chk("bp_load_cnt_r", cnt_r, 1);
        r_valid = 1'b0; i_valid = 1'b1; ibits = 3'b110; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_i_ready", i_ready, 0);
            tick();
            chk("bp_hold_out_bits", out_bits, 3'b011);
            chk("bp_hold_out_valid", out_valid, 1);
            chk("bp_hold_cnt_i", cnt_i, 0);
            $display("vec backpressure cycle %0d: out_bits=%b i_ready=%0d", k, out_bits, i_ready);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_i_ready", i_ready, 1);
        tick();
        chk("bp_release_out_bits", out_bits, 3'b110);
        chk("bp_release_mux_sel",  mux_sel, 1);
        chk("bp_release_cnt_i",    cnt_i, 1);
        $display("vec backpressure release: out_bits=%b cnt_i=%0d", out_bits, cnt_i);

        // Register only, then idle, then a tie
        i_valid = 1'b0; r_valid = 1'b1; rbits = 3'b001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ronly_r_ready", r_ready, 1);
            chk("ronly_i_ready", i_ready, 0);
            tick();
            chk("ronly_out_bits", out_bits, 3'b001);
            chk("ronly_mux_sel",  mux_sel, 0);
            $display("vec reg only %0d: out_bits=%b cnt_r=%0d", k, out_bits, cnt_r);
        end
        chk("ronly_cnt_r_sat", cnt_r, 3);
        r_valid = 1'b0;
        tick(); tick();
        chk("idle_out_valid", out_valid, 0);
        i_valid = 1'b1; r_valid = 1'b1; ibits = 3'b111; rbits = 3'b100;
        #1;
        chk("tie_after_reg_i_ready", i_ready, 1);
        chk("tie_after_reg_r_ready", r_ready, 0);
        tick();
        chk("tie_after_reg_out_bits", out_bits, 3'b111);
        $display("vec tie after reg: out_bits=%b", out_bits);

        // Counter saturation and clear priority
        r_valid = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr_cnt_i", cnt_i, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_cnt_i", cnt_i, (k > 3) ? 3 : k);
            $display("vec saturation grant %0d: cnt_i=%0d", k, cnt_i);
        end
        cnt_clr = 1'b1;
        #1;
        chk("clr_grant_i_ready", i_ready, 1);
        tick();
        cnt_clr = 1'b0;
        chk("clr_grant_cnt_i", cnt_i, 0);
        $display("vec clear with grant: cnt_i=%0d", cnt_i);

        // Asynchronous reset while FULL and stalled
        out_ready = 1'b0; ibits = 3'b010;
        tick();
        chk("async_pre_out_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_bits",  out_bits,  0);
        chk("async_i_ready",   i_ready,   0);
        $display("vec async reset: out_valid=%0d", out_valid);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_i_ready", i_ready, 1);
        tick();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_bits",  out_bits, 3'b010);
        chk("post_rst_cnt_i",     cnt_i, 1);
        $display("vec post reset regrant: out_bits=%b cnt_i=%0d", out_bits, cnt_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/rs_operand_arbiter.md
# rs_operand_arbiter

Round-robin arbiter and output register for the shared register-source operand path. Two producers compete for it: the immediate path (ibits) and the register-file path (rbits). The block picks a winner each cycle, drives the select of the 2:1 rs operand mux, and captures the muxed operand into a one-entry output register with a valid/ready handshake toward the execute stage. It also keeps saturating per-requester grant counters for performance observation.

## Interface
- N, default 2: operand MSB index; operand width is N+1 bits.
- CW, default 16: width of each grant counter.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  immediate requester has an operand.
- ibits  in  N+1  immediate operand.
- i_ready  out  1  immediate operand accepted this cycle.
- r_valid  in  1  register requester has an operand.
- rbits  in  N+1  register operand.
- r_ready  out  1  register operand accepted this cycle.
- mux_sel  out  1  registered select of the winning source: 1 = ibits, 0 = rbits.
- out_valid  out  1  output register holds an operand.
- out_bits  out  N+1  registered operand.
- out_ready  in  1  consumer accepts out_bits this cycle.
- cnt_i  out  CW  saturating count of immediate grants.
- cnt_r  out  CW  saturating count of register grants.
- cnt_clr  in  1  synchronous clear of both counters.

## Operation
- State:
  - output register: out_valid, out_bits, mux_sel.
  - last_sel: the source most recently granted.
  - the two counters.
- Two-state output FSM:
  - EMPTY (out_valid=0) -> FULL on any grant.
  - FULL -> EMPTY when out_ready=1 and no new grant.
  - FULL -> FULL when out_ready=1 with a grant (pass-through), or when out_ready=0 (hold).
- load_en = !out_valid | out_ready.
- Arbitration, evaluated combinationally each cycle, only when load_en=1:
  - only i_valid: grant imm.
  - only r_valid: grant reg.
  - both valid: grant the source opposite to last_sel (round-robin).
  - neither valid: no grant.
- i_ready = load_en & grant_imm; r_ready = load_en & grant_reg. At most one of them is 1 in any cycle.
- On a grant:
  - out_bits <= selected operand (ibits if imm, else rbits).
  - mux_sel <= 1 for imm, 0 for reg.
  - last_sel <= granted source.
  - out_valid <= 1.
  - increment the granted counter.
- While FULL and out_ready=0, out_bits, mux_sel and out_valid hold stable. Requesters see ready=0.
- Counters:
  - each saturates at 2^CW-1 (no wrap).
  - cnt_clr has priority over increment; a cleared counter reads 0 the next cycle.
- last_sel changes only on a grant. Idle cycles do not advance the round-robin pointer.

## Timing
- Reset (asynchronous assert, synchronous deassert by the surrounding system):
  - out_valid=0, out_bits=0, mux_sel=0.
  - last_sel=reg, so the first tie grants imm.
  - cnt_i=0, cnt_r=0.
  - i_ready and r_ready are forced 0 while reset is high.
- Latency: an operand accepted in cycle t (valid & ready both 1) appears on out_bits with out_valid=1 in cycle t+1.
- Throughput: one operand per cycle when out_ready is held 1.
- Fairness under continuous contention: grants strictly alternate imm, reg, imm, ...
- Handshake rules:
  - requesters must hold valid and bits stable until their ready is seen high.
  - ready may depend combinationally on valid and out_ready.
  - out_valid does not depend combinationally on out_ready.
- Simultaneous pop and push (FULL, out_ready=1, grant): the new operand replaces the old one at the edge, and out_valid stays 1.
- Reset mid-operation: any held operand is discarded, out_valid drops immediately (asynchronously), and no ready is issued until reset is released.

## Test plan
- Reset with i_valid=r_valid=1: during reset all outputs are 0 and both readys are 0. First cycle after release: i_ready=1. Next cycle: out_bits=ibits, mux_sel=1, cnt_i=1.
- Both requesters valid continuously, out_ready=1, ibits=3'b101, rbits=3'b010: out_bits sequence 101, 010, 101, 010. mux_sel toggles 1, 0, 1, 0. After 4 grants, cnt_i=2 and cnt_r=2.
- Backpressure: load rbits=3'b011, then hold out_ready=0 for 5 cycles with i_valid=1. Required: out_bits stays 011, i_ready stays 0, cnt_i stays unchanged. When out_ready rises, i_ready=1 in the same cycle and out_bits=ibits in the next.
- Only r_valid, for 3 cycles, then both valid: reg is granted 3 times, then the tie grants imm (last_sel=reg). Idle cycles inserted in between do not alter the order.
- Saturation with CW=2: 5 consecutive imm grants give cnt_i=3 and hold there. Asserting cnt_clr together with a grant gives cnt_i=0 next cycle.
- Reset asserted while FULL with out_ready=0: out_valid goes to 0 without waiting for a clock edge. After release, the pending requester is re-granted normally.
